// File: rtl/antenna_scaler_bank.sv
`default_nettype none
// ============================================================================
// Module   : antenna_scaler_bank
// Purpose  : N-channel antenna front-end with masked edge accept, dead-time
//            stretching, gated saturating scalers and a multiplicity trigger.
//            Optional per-channel hit history built when SCALER_HIST_EN is set.
// Revision : 1.0  initial release
// ============================================================================
module antenna_scaler_bank #(
    parameter int N_CH      = 8,
    parameter int CNT_W     = 24,
    parameter int GATE_LOG2 = 23,
    parameter int DEAD_CYC  = 4,
    parameter int WIN_CYC   = 20,
    parameter int HIST_D    = 24
) (
    input  logic                   clk_r2,
    input  logic                   reset,
    input  logic [N_CH-1:0]        antennaI,
    input  logic [N_CH-1:0]        mask,
    input  logic [3:0]             trig_th,
    input  logic                   hist_freeze,
    output logic [N_CH-1:0]        antennaOw,
    output logic                   triggerAnt,
    output logic [N_CH*CNT_W-1:0]  scaler_out,
    output logic [N_CH-1:0]        scaler_ovf,
    output logic                   scaler_valid,
    output logic [N_CH*HIST_D-1:0] hist_out,
    output logic [3:0]             mult_out
);

    localparam logic [5:0] c_DEAD = 6'(DEAD_CYC);
    localparam logic [5:0] c_WIN  = 6'(WIN_CYC);

    logic [N_CH-1:0]      in_q;
    logic [N_CH-1:0]      prev_q;
    logic [N_CH-1:0]      w_rise;
    logic [N_CH-1:0]      w_win;
    logic [GATE_LOG2-1:0] gate_q;
    logic                 w_wrap;
    logic                 valid_q;
    logic [3:0]           mult_q;
    logic [3:0]           mult_d;
    logic [3:0]           mult_prev_q;
    logic                 trig_q;
    logic                 trig_d;

    assign w_rise = in_q & ~prev_q;
    assign w_wrap = &gate_q;

    always_comb begin
        mult_d = '0;
        for (int j = 0; j < N_CH; j++) begin
            mult_d = mult_d + {3'b000, w_win[j]};
        end
    end

    // Rising-edge-of-threshold detect: re-arms only once multiplicity falls below.
    assign trig_d = (trig_th != 4'd0) && (mult_q >= trig_th) && (mult_prev_q < trig_th);

    always_ff @(posedge clk_r2) begin
        if (reset) begin
            in_q        <= '0;
            prev_q      <= '0;
            gate_q      <= '0;
            valid_q     <= 1'b0;
            mult_q      <= '0;
            mult_prev_q <= '0;
            trig_q      <= 1'b0;
        end else begin
            in_q        <= antennaI;
            prev_q      <= in_q;
            gate_q      <= gate_q + GATE_LOG2'(1);
            valid_q     <= w_wrap;
            mult_q      <= mult_d;
            mult_prev_q <= mult_q;
            trig_q      <= trig_d;
        end
    end

    assign triggerAnt   = trig_q;
    assign scaler_valid = valid_q;
    assign mult_out     = mult_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [5:0]       dead_q;
        logic [5:0]       dead_d;
        logic [5:0]       win_q;
        logic [5:0]       win_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] lat_q;
        logic             ovf_q;
        logic             ovf_d;
        logic             lat_ovf_q;
        logic             w_acc;
        logic             w_ow;

        // Only a counter already at zero admits a new edge, so expiry wins a tie.
        assign w_acc = w_rise[i] & mask[i] & (dead_q == 6'd0);
        assign w_ow  = (dead_q != 6'd0);

        always_comb begin
            dead_d = dead_q;
            win_d  = win_q;
            cnt_d  = cnt_q;
            ovf_d  = ovf_q;
            if (w_acc) begin
                dead_d = c_DEAD;
            end else if (dead_q != 6'd0) begin
                dead_d = dead_q - 6'd1;
            end
            if (w_acc) begin
                win_d = c_WIN;
            end else if (win_q != 6'd0) begin
                win_d = win_q - 6'd1;
            end
            // A hit landing on the wrap cycle belongs to the new gate.
            if (w_wrap) begin
                cnt_d = CNT_W'(w_acc);
                ovf_d = 1'b0;
            end else if (w_acc) begin
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_r2) begin
            if (reset) begin
                dead_q    <= '0;
                win_q     <= '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
                lat_q     <= '0;
                lat_ovf_q <= 1'b0;
            end else begin
                dead_q <= dead_d;
                win_q  <= win_d;
                cnt_q  <= cnt_d;
                ovf_q  <= ovf_d;
                if (w_wrap) begin
                    lat_q     <= cnt_q;
                    lat_ovf_q <= ovf_q;
                end
            end
        end

        assign antennaOw[i]                   = w_ow;
        assign w_win[i]                       = (win_q != 6'd0);
        assign scaler_out[i*CNT_W +: CNT_W]   = lat_q;
        assign scaler_ovf[i]                  = lat_ovf_q;

`ifdef SCALER_HIST_EN
        logic [HIST_D-1:0] hist_q;
        logic [HIST_D-1:0] hist_d;

        always_comb begin
            hist_d = hist_q;
            if (!hist_freeze) begin
                hist_d = (hist_q << 1) | HIST_D'(w_ow);
            end
        end

        always_ff @(posedge clk_r2) begin
            if (reset) begin
                hist_q <= '0;
            end else begin
                hist_q <= hist_d;
            end
        end

        assign hist_out[i*HIST_D +: HIST_D] = hist_q;
`else
        assign hist_out[i*HIST_D +: HIST_D] = '0;
`endif
    end

`ifndef SCALER_HIST_EN
    logic w_unused_freeze;
    assign w_unused_freeze = hist_freeze;
`endif

endmodule
`default_nettype wire

// File: tb/tb_antenna_scaler_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_antenna_scaler_bank
// Purpose  : Self-checking bench: time-based reference model, trigger vector
//            table and directed multi-cycle sequences for antenna_scaler_bank.
// Revision : 1.0  initial release
// ============================================================================
module tb_antenna_scaler_bank;

    localparam int N    = 8;
    localparam int CW   = 4;
    localparam int GL   = 8;
    localparam int DC   = 4;
    localparam int WC   = 20;
    localparam int HD   = 24;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ain;
    logic [N-1:0]    msk;
    logic [3:0]      th;
    logic            frz;
    logic [N-1:0]    ow;
    logic            trig;
    logic [N*CW-1:0] sout;
    logic [N-1:0]    sovf;
    logic            svalid;
    logic [N*HD-1:0] hout;
    logic [3:0]      mult;

    int checks = 0;
    int errors = 0;
    bit mdl_on = 1'b0;

    antenna_scaler_bank #(
        .N_CH(N), .CNT_W(CW), .GATE_LOG2(GL), .DEAD_CYC(DC), .WIN_CYC(WC), .HIST_D(HD)
    ) dut (
        .clk_r2(clk), .reset(rst), .antennaI(ain), .mask(msk), .trig_th(th),
        .hist_freeze(frz), .antennaOw(ow), .triggerAnt(trig), .scaler_out(sout),
        .scaler_ovf(sovf), .scaler_valid(svalid), .hist_out(hout), .mult_out(mult)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: tracks edge index since reset and the edge of each
    // channel's last accepted hit; outputs follow from elapsed-time rules.
    int              e_m;
    int              last_acc[N];
    int              n_hits[N];
    logic [N-1:0]    pend_m, sprev_m, ow_m, flag_m, ovf_m;
    logic [N*CW-1:0] out_m;
    logic            valid_m, trig_m;
    logic [3:0]      mult_m, mult_p;
    logic [HD-1:0]   hist_m[N];
    logic [N*HD-1:0] histv_m;

    task automatic model_step();
        logic [N-1:0] ow_old;
        logic [N-1:0] flag_old;
        logic [N-1:0] acc;
        int           pc;
        if (rst) begin
            e_m = 0;
            for (int i = 0; i < N; i++) begin
                last_acc[i] = -1000;
                n_hits[i]   = 0;
                hist_m[i]   = '0;
            end
            pend_m = '0; sprev_m = '0; ow_m = '0; flag_m = '0; ovf_m = '0;
            out_m = '0; valid_m = 1'b0; trig_m = 1'b0; mult_m = '0; mult_p = '0;
        end else begin
            ow_old   = ow_m;
            flag_old = flag_m;
            e_m++;
            for (int i = 0; i < N; i++) begin
                acc[i]     = pend_m[i] && msk[i] && ((e_m - last_acc[i]) > DC);
                pend_m[i]  = ain[i] && !sprev_m[i];
                sprev_m[i] = ain[i];
            end
            valid_m = 1'b0;
            if ((e_m % (1 << GL)) == 0) begin
                valid_m = 1'b1;
                for (int i = 0; i < N; i++) begin
                    out_m[i*CW +: CW] = (n_hits[i] > MAXC) ? CW'(MAXC) : CW'(n_hits[i]);
                    ovf_m[i]          = (n_hits[i] > MAXC);
                    n_hits[i]         = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    n_hits[i]++;
                    last_acc[i] = e_m;
                end
                ow_m[i]   = (e_m - last_acc[i]) < DC;
                flag_m[i] = (e_m - last_acc[i]) < WC;
            end
            trig_m = (th != 4'd0) && (mult_m >= th) && (mult_p < th);
            mult_p = mult_m;
            pc = 0;
            for (int i = 0; i < N; i++) pc += int'(flag_old[i]);
            mult_m = 4'(pc);
`ifdef SCALER_HIST_EN
            if (!frz) begin
                for (int i = 0; i < N; i++) hist_m[i] = {hist_m[i][HD-2:0], ow_old[i]};
            end
`endif
        end
        for (int i = 0; i < N; i++) histv_m[i*HD +: HD] = hist_m[i];
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("mdl_antennaOw", ow, ow_m);
            chk("mdl_triggerAnt", trig, trig_m);
            chk("mdl_mult_out", mult, mult_m);
            chk("mdl_scaler_valid", svalid, valid_m);
            chk("mdl_scaler_out", sout, out_m);
            chk("mdl_scaler_ovf", sovf, ovf_m);
            chk("mdl_hist_out", hout, histv_m);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ain = '0; frz = 1'b0; msk = 8'hFF; th = 4'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (svalid === 1'b1) begin
                cyc = c;
                break;
            end
        end
        chk("valid_seen", (cyc > 0), 1'b1);
    endtask

    typedef struct {
        logic [7:0] hits;
        logic [7:0] vmsk;
        logic [3:0] vth;
        logic [3:0] emult;
        logic       etrig;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          cyc;
        logic [11:0] owpat;
        logic [63:0] trigpat;
        logic [3:0]  m13;
        logic        ow2_seen;
        logic        mult_seen;
        int          npulse;

        tbl[0] = '{8'hFF, 8'hFF, 4'd8, 4'd8, 1'b1};
        tbl[1] = '{8'h0F, 8'hFF, 4'd5, 4'd4, 1'b0};
        tbl[2] = '{8'h0F, 8'h03, 4'd2, 4'd2, 1'b1};
        tbl[3] = '{8'h81, 8'hFF, 4'd0, 4'd2, 1'b0};
        tbl[4] = '{8'h01, 8'hFF, 4'd1, 4'd1, 1'b1};
        tbl[5] = '{8'hF0, 8'h0F, 4'd1, 4'd0, 1'b0};
        tbl[6] = '{8'hAA, 8'hFF, 4'd4, 4'd4, 1'b1};
        tbl[7] = '{8'h7F, 8'hFF, 4'd7, 4'd7, 1'b1};

        rst = 1'b1; ain = '0; msk = '0; th = '0; frz = 1'b0;
        do_reset();
        mdl_on = 1'b1;
        chk("rst_scaler_out", sout, '0);
        chk("rst_scaler_ovf", sovf, '0);
        chk("rst_scaler_valid", svalid, 1'b0);
        chk("rst_antennaOw", ow, '0);
        chk("rst_triggerAnt", trig, 1'b0);
        chk("rst_mult_out", mult, '0);
        chk("rst_hist_out", hout, '0);

        // Ten spaced pulses on ch0 within the first gate.
        for (int p = 0; p < 10; p++) begin
            ain = 8'h01;
            @(negedge clk);
            ain = 8'h00;
            idle(9);
        end
        wait_valid(cyc);
        chk("count10_scaler_out", sout, 32'h0000_000A);
        chk("count10_scaler_ovf", sovf, 8'h00);

        // Reset mid-gate clears scalers; first valid lands 2^GL cycles later.
        idle(50);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_scaler_out", sout, '0);
        rst = 1'b0;
        wait_valid(cyc);
        chk("midrst_valid_latency", cyc, 256);
        chk("midrst_empty_gate", sout, '0);

        // Dead time: pulses on ch1 at cycles 0, 2, 5.
        do_reset();
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            owpat[j] = ow[1];
            ain = (j == 0 || j == 2 || j == 5) ? 8'h02 : 8'h00;
        end
        chk("dead_ow_pattern", owpat, 12'b0111_1011_1100);
        wait_valid(cyc);
        chk("dead_count", sout, 32'h0000_0020);

        // Masked channel ignored entirely.
        do_reset();
        msk = 8'hFB;
        ow2_seen = 1'b0; mult_seen = 1'b0;
        for (int j = 0; j < 60; j++) begin
            if (j > 0) @(negedge clk);
            ow2_seen  |= ow[2];
            mult_seen |= (mult != 4'd0);
            ain = ((j % 10) == 0 && j < 50) ? 8'h04 : 8'h00;
        end
        chk("mask_ow2", ow2_seen, 1'b0);
        chk("mask_mult", mult_seen, 1'b0);
        wait_valid(cyc);
        chk("mask_count", sout, '0);

        // Saturation then an empty gate.
        do_reset();
        for (int p = 0; p < 20; p++) begin
            ain = 8'h08;
            @(negedge clk);
            ain = 8'h00;
            idle(5);
        end
        wait_valid(cyc);
        chk("sat_scaler_out", sout, 32'h0000_F000);
        chk("sat_scaler_ovf", sovf, 8'h08);
        wait_valid(cyc);
        chk("sat_next_gate_period", cyc, 256);
        chk("sat_next_scaler_out", sout, '0);
        chk("sat_next_scaler_ovf", sovf, 8'h00);

        // Trigger: three channels inside one window.
        do_reset();
        th = 4'd3;
        trigpat = '0; m13 = '0;
        for (int j = 0; j < 41; j++) begin
            if (j > 0) @(negedge clk);
            trigpat[j] = trig;
            if (j == 13) m13 = mult;
            ain = (j == 0) ? 8'h01 : (j == 5) ? 8'h10 : (j == 10) ? 8'h80 : 8'h00;
        end
        chk("trig_pattern", trigpat, 64'h0000_0000_0000_4000);
        chk("trig_mult", m13, 4'd3);
        th = 4'd0;
        npulse = 0;
        for (int j = 0; j < 41; j++) begin
            @(negedge clk);
            npulse += int'(trig);
            ain = (j == 0) ? 8'h01 : (j == 5) ? 8'h10 : (j == 10) ? 8'h80 : 8'h00;
        end
        chk("trig_disabled", npulse, 0);

        // Table of simultaneous-hit multiplicity/trigger vectors.
        idle(30);
        for (int v = 0; v < 8; v++) begin
            msk = tbl[v].vmsk; th = tbl[v].vth; ain = tbl[v].hits;
            @(negedge clk);
            ain = 8'h00;
            idle(2);
            chk($sformatf("tbl%0d_mult", v), mult, tbl[v].emult);
            @(negedge clk);
            chk($sformatf("tbl%0d_trig", v), trig, tbl[v].etrig);
            idle(30);
        end

`ifdef SCALER_HIST_EN
        do_reset();
        for (int j = 0; j < 9; j++) begin
            if (j > 0) @(negedge clk);
            ain = (j == 0) ? 8'h20 : 8'h00;
            if (j == 8) frz = 1'b1;
        end
        @(negedge clk);
        chk("hist_ch5_frozen", hout[5*HD +: HD], 24'h00_003C);
        idle(20);
        chk("hist_ch5_hold", hout[5*HD +: HD], 24'h00_003C);
        rst = 1'b1;
        @(negedge clk);
        chk("hist_rst_clear", hout, '0);
        rst = 1'b0; frz = 1'b0;
`else
        chk("hist_tied_zero", hout, '0);
`endif

        // Randomised traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c < 750) ain = 8'($urandom & $urandom & $urandom);
            else         ain = 8'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) msk = 8'($urandom);
            if ($urandom_range(0, 31) == 0) th = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) frz = ~frz;
            rst = (c == 777);
        end
        rst = 1'b0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/antenna_scaler_bank.md
# antenna_scaler_bank

Parametrised N-channel antenna front-end for the station trigger FPGA. Per channel it does edge detection with masking, dead-time/pulse stretching, and a saturating rate scaler latched on a power-of-two gate. It also keeps an optional frozen-on-demand hit history. A multiplicity coincidence trigger is built over all channels. It replaces fixed 8-channel, hard-coded-delay pulse logic and feeds the scaler readout registers and the global trigger.

## Interface
- N_CH, 8, number of antenna channels (1..15)
- CNT_W, 24, scaler counter width
- GATE_LOG2, 23, scaler gate length = 2^GATE_LOG2 cycles
- DEAD_CYC, 4, dead time / stretched pulse length in cycles (1..63)
- WIN_CYC, 20, coincidence window length in cycles (1..63)
- HIST_D, 24, history depth in cycles per channel

- clk_r2  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- antennaI  in  N_CH  raw discriminator inputs, already in clk_r2 domain
- mask  in  N_CH  1 = channel enabled, 0 = channel ignored (no hits, no scaler, no trigger)
- trig_th  in  4  multiplicity threshold; 0 disables trigger
- hist_freeze  in  1  1 = hold history contents
- antennaOw  out  N_CH  stretched accepted hits
- triggerAnt  out  1  one-cycle multiplicity trigger pulse
- scaler_out  out  N_CH*CNT_W  latched counts; channel i at [i*CNT_W +: CNT_W]
- scaler_ovf  out  N_CH  latched per-channel saturation flags
- scaler_valid  out  1  one-cycle pulse when scaler_out/scaler_ovf update
- hist_out  out  N_CH*HIST_D  history; channel i at [i*HIST_D +: HIST_D], bit 0 newest
- mult_out  out  4  current multiplicity (registered)

## Operation
- Input stage: antennaI is registered once. A rising edge is detected as sampled & ~previous-sample.
- Accept: an edge is accepted when mask[i]=1 and the channel dead counter is 0. The accepted edge loads the dead counter with DEAD_CYC. While the dead counter is nonzero, antennaOw[i]=1 and further edges are discarded, so they are not counted. The counter decrements to 0.
- Scaler: the running counter increments on each accepted hit. At all-ones it holds and sets the running ovf flag.
- Gate: a GATE_LOG2-bit free-running counter. At its all-ones cycle, running counts and ovf are copied to scaler_out/scaler_ovf, and scaler_valid pulses at the next edge. The running counters restart at 0. A hit in the wrap cycle counts as 1 in the new gate, not the old one.
- Coincidence: each accepted hit (re)loads a window counter with WIN_CYC; the window flag = counter≠0. mult_out = popcount of the flags, registered.
- Trigger: triggerAnt=1 for one cycle when trig_th≠0, mult_out≥trig_th, and the previous cycle's mult_out<trig_th. It re-arms only after the multiplicity drops below threshold.
- History: per channel, a HIST_D shift register of antennaOw[i] shifts each cycle while hist_freeze=0. It holds while hist_freeze=1.
- Mask change mid-pulse: dead and window counters run out normally. Only new accepts are blocked.

## Timing
- antennaI rise at edge k (sampled) -> accept at edge k+1 -> antennaOw high cycles k+1..k+DEAD_CYC. Running count and window flag update at edge k+1.
- mult_out reflects a hit at edge k+2; triggerAnt goes high at edge k+3.
- scaler_valid goes high one cycle after the gate all-ones cycle. scaler_out is stable for the whole following gate.
- Reset values: all outputs 0, gate counter 0, running counters, ovf flags, dead/window counters and history all 0. The first scaler_valid occurs 2^GATE_LOG2 cycles after reset release.
- Reset asserted mid-gate discards the partial gate; scaler_out is cleared.
- Accept and dead-counter expiry in the same cycle: expiry wins; an edge is accepted only when the counter is already 0 at that edge.

## Configuration
- SCALER_HIST_EN: when defined, the history shift registers and hist_freeze logic are built.
- When undefined, hist_out is tied to 0, hist_freeze is ignored, and no history flops are inferred.

## Test plan
- N_CH=8, GATE_LOG2=8, DEAD_CYC=4: 10 single-cycle pulses 10 cycles apart on ch0, mask=8'hFF -> at the first scaler_valid, ch0 count=10, other channels 0, ovf=0.
- Dead time: ch1 pulses at cycles 0 and 2, then 5 -> 2 accepts (0 and 5); antennaOw[1] high 4 cycles each.
- Mask: ch2 pulsed 5 times with mask[2]=0 -> count 0, antennaOw[2]=0, mult_out unaffected.
- Saturation: CNT_W=4, ch3 20 accepted hits in one gate -> scaler_out ch3=15, scaler_ovf[3]=1; next gate with 0 hits -> 0/0.
- Trigger: trig_th=3, hits on ch0/ch4/ch7 within 20 cycles -> exactly one triggerAnt pulse 2 cycles after the third accept. With trig_th=0 there is no pulse.
- History (SCALER_HIST_EN): hit on ch5, assert hist_freeze 6 cycles after the accept -> hist_out ch5 bits [5:2]=1 and stays constant while frozen. Reset mid-freeze clears it to 0.
